pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch-sequencing stage directly upstream of the word-addressed
//  instruction memory. Holds the byte PC and drives it as the I-MEM read address.
//  Computes next PC (sequential, branch, jump), honours stall, and halts after a run
//  of all-zero (unfilled) instruction words.
// PARAMETERS
//  ADDR_W      8    PC / byte-address width; I-MEM word index = pc[ADDR_W-1:2]
//  RESET_PC    0    PC value loaded on reset; bits [1:0] must be 0
//  HALT_ZEROS  2    consecutive valid all-zero instructions that trigger HALT (>=1)
//  CNT_W       16   width of performance counters (FETCH_PERF_EN only)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high reset
//  stall          in   1       hold PC this cycle
//  branch_taken   in   1       take branch at end of current cycle
//  branch_offset  in   16      signed word offset (I-type immediate)
//  jump           in   1       take jump at end of current cycle
//  jump_index     in   26      J-type word index
//  halt_req       in   1       force HALT at next edge
//  instruction    in   32      word returned by I-MEM for current pc
//  pc             out  ADDR_W  current PC, wired to I-MEM read address
//  pc_plus4       out  ADDR_W  pc + 4 (mod 2^ADDR_W), combinational
//  instr_valid    out  1       instruction is a live fetch this cycle
//  halted         out  1       unit is in HALT
//  fetch_count    out  CNT_W   FETCH_PERF_EN only: retired fetches
//  redirect_count out  CNT_W   FETCH_PERF_EN only: branch/jump redirects taken
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=INIT, instr_valid=0, halted=0, zero-run=0,
//    counters=0. Reset asserted mid-operation aborts everything at once, no flush cycle.
//  - FSM INIT -> RUN -> HALT. INIT lasts exactly 1 cycle after reset release, giving
//    I-MEM its load window. PC holds, instr_valid=0, then RUN.
//  - RUN: instr_valid = ~stall. At each edge, priority order:
//    halt_req > stall > jump > branch_taken > sequential.
//      halt_req : -> HALT, pc holds.
//      stall    : pc holds; zero-run counter holds.
//      jump     : pc = {jump_index[ADDR_W-3:0], 2'b00}.
//      branch   : pc = pc_plus4 + (sext(branch_offset) << 2), truncated to ADDR_W.
//      else     : pc = pc_plus4.
//    jump and branch_taken together: jump wins.
//  - Wrap-around: all PC arithmetic is modulo 2^ADDR_W. 0xFC+4 -> 0x00 with no flag.
//    pc[1:0] is always 00 by construction.
//  - Halt detection: on each valid (non-stalled) RUN cycle, zero-run++ if
//    instruction==32'h0, else zero-run=0. The edge where zero-run would reach HALT_ZEROS
//    enters HALT. That fetch still counts, and pc does not advance on it.
//  - HALT: pc frozen, instr_valid=0, halted=1. All inputs ignored. Exit only via reset.
//  - Latency: redirect visible on pc one cycle after the request (registered PC).
//    pc_plus4 is combinational from pc.
// CONFIGURATION
//  FETCH_PERF_EN defined: fetch_count increments on every valid RUN cycle.
//    redirect_count increments on taken jump/branch edges that are not stalled.
//    Both saturate at all-ones and reset to 0.
//  FETCH_PERF_EN undefined: counter logic and both ports are absent.
//    Functional behaviour is otherwise identical.
// TESTING
//  1 reset 3 cycles, release, nonzero instrs -> pc 0x00 for 2 cycles (INIT+first),
//    then 0x04,0x08,0x0C. instr_valid low in INIT only.
//  2 at pc=0x10 branch_taken, offset=-2 -> pc=0x0C. Offset=+3 -> pc=0x20.
//  3 at pc=0x08 jump=1, branch_taken=1, jump_index=0x00000A -> pc=0x28 (jump wins).
//  4 stall high 3 cycles at pc=0x14 -> pc stays 0x14, instr_valid=0, then resumes 0x18.
//  5 instruction=0 from pc=0x78, HALT_ZEROS=2 -> halted=1 after 2nd zero fetch,
//    pc frozen at 0x7C. Reset mid-HALT -> pc=0, halted=0.
//  6 pc=0xFC sequential -> 0x00. With FETCH_PERF_EN, after tests 1-2
//    fetch_count/redirect_count match the expected fetch and redirect totals.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding a word-addressed instruction memory.
// Optional performance counters are built when the FETCH_PERF_EN macro is defined.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       HALT_ZEROS = 2,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              halt_req,
    input  logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  redirect_count
`endif
);

    localparam int unsigned       ZR_W    = $clog2(HALT_ZEROS + 1);
    localparam logic [ZR_W-1:0]   ZR_LAST = ZR_W'(HALT_ZEROS - 1);

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ZR_W-1:0]   zero_run_q, zero_run_d;

    logic                 fetch_valid;
    logic                 zero_instr;
    logic                 zero_halt;
    logic                 redirect;
    logic [ADDR_W+17:0]   branch_off_ext;
    logic [ADDR_W-1:0]    branch_target;
    logic [ADDR_W-1:0]    jump_target;

    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign pc          = pc_q;
    assign fetch_valid = (state_q == StRun) && !stall;
    assign instr_valid = fetch_valid;
    assign halted      = (state_q == StHalt);
    assign zero_instr  = (instruction == 32'h0);
    // The fetch that completes the zero run halts in place instead of advancing.
    assign zero_halt   = fetch_valid && !halt_req && zero_instr && (zero_run_q == ZR_LAST);

    // Word offset sign-extended and scaled to bytes; only the low ADDR_W bits matter.
    assign branch_off_ext = {{ADDR_W{branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_target  = pc_plus4 + branch_off_ext[ADDR_W-1:0];
    assign jump_target    = {jump_index[ADDR_W-3:0], 2'b00};

    assign redirect = fetch_valid && !halt_req && !zero_halt && (jump || branch_taken);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        zero_run_d = zero_run_q;
        unique case (state_q)
            StInit: begin
                state_d = StRun;
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (!stall) begin
                    if (zero_halt) begin
                        state_d    = StHalt;
                        zero_run_d = zero_run_q + ZR_W'(1);
                    end else begin
                        zero_run_d = zero_instr ? zero_run_q + ZR_W'(1) : '0;
                        if (jump) begin
                            pc_d = jump_target;
                        end else if (branch_taken) begin
                            pc_d = branch_target;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            pc_q       <= RESET_PC;
            zero_run_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            zero_run_q <= zero_run_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (fetch_valid && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
        if (redirect && (redirect_count_q != '1)) begin
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`else
    logic             unused_redirect;
    logic [CNT_W-1:0] unused_cnt;
    assign unused_redirect = redirect;
    assign unused_cnt      = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{jump_index[25:ADDR_W-2], branch_off_ext[ADDR_W+17:ADDR_W]};

endmodule
